// File: rtl/bj_pkg.sv
// Shared definitions for the BlackJack card path: FSM state codes, rank codes and LFSR defaults.
package bj_pkg;
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_PICK  = 4'd2,
    ST_RD_I  = 4'd3,
    ST_RD_J  = 4'd4,
    ST_WR_I  = 4'd5,
    ST_WR_J  = 4'd6,
    ST_NEXT  = 4'd7,
    ST_READY = 4'd8,
    ST_DEAL  = 4'd9
  } state_t;

  localparam int          N_RANKS      = 13;
  localparam logic [3:0]  RANK_ACE     = 4'd1;
  localparam logic [3:0]  RANK_KING    = 4'd13;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR16_TAPS  = 16'hB400;
endpackage

// File: rtl/bj_lfsr.sv
// Free-running Galois LFSR; shifts right every cycle, feedback from bit 0.
module bj_lfsr
  import bj_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEFAULT_SEED),
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(LFSR16_TAPS)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  output logic [LFSR_W-1:0] o_Lfsr
);
  logic [LFSR_W-1:0] r_Lfsr;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_Lfsr <= LFSR_SEED;
    else         r_Lfsr <= (r_Lfsr >> 1) ^ (r_Lfsr[0] ? TAPS : '0);
  end

  assign o_Lfsr = r_Lfsr;
endmodule

// File: rtl/card_deck_shuffler.sv
// N-deck shoe: fills a sync-read RAM in rank order, Fisher-Yates shuffles it with
// LFSR rejection sampling, then deals one card per request.
module card_deck_shuffler
  import bj_pkg::*;
#(
  parameter int                N_DECKS   = 1,
  parameter int                CARD_W    = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEFAULT_SEED),
  parameter int                LOW_MARK  = 15,
  localparam int               DECK_SIZE = 52 * N_DECKS,
  localparam int               ADDR_W    = $clog2(DECK_SIZE),
  localparam int               CNT_W     = $clog2(DECK_SIZE + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Shuffle,
  input  logic              i_Deal,
  output logic [CARD_W-1:0] o_Card,
  output logic              o_CardValid,
  output logic              o_Busy,
  output logic              o_Ready,
  output logic              o_Empty,
  output logic              o_LowDeck,
  output logic [CNT_W-1:0]  o_Remaining,
  output logic [3:0]        o_State
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);

  state_t              r_State, w_Next;
  logic [LFSR_W-1:0]   w_Lfsr;
  logic [ADDR_W-1:0]   r_K, r_I, r_J, r_Ptr, w_Cand, w_Addr;
  logic [CARD_W-1:0]   r_Rank, r_Ti, r_RdData, r_Card, w_WrData;
  logic [CARD_W-1:0]   r_Mem [DECK_SIZE];
  logic [CNT_W-1:0]    r_Remaining;
  logic                r_CardValid, w_We, w_Busy, w_Ready, w_Empty;
  logic                w_unused_lfsr;

  bj_lfsr #(.LFSR_W(LFSR_W), .LFSR_SEED(LFSR_SEED)) u_lfsr (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .o_Lfsr(w_Lfsr)
  );

  assign w_Cand        = w_Lfsr[ADDR_W-1:0];
  assign w_unused_lfsr = ^w_Lfsr[LFSR_W-1:ADDR_W];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_State <= ST_IDLE;
    else         r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      ST_IDLE:  if (i_Shuffle) w_Next = ST_INIT;
      ST_INIT:  if (r_K == LAST) w_Next = ST_PICK;
      ST_PICK:  if (w_Cand <= r_I) w_Next = ST_RD_I;
      ST_RD_I:  w_Next = ST_RD_J;
      ST_RD_J:  w_Next = ST_WR_I;
      ST_WR_I:  w_Next = ST_WR_J;
      ST_WR_J:  w_Next = ST_NEXT;
      ST_NEXT:  w_Next = (r_I == ADDR_W'(1)) ? ST_READY : ST_PICK;
      // Shuffle has priority over a coincident deal
      ST_READY: if (i_Shuffle) w_Next = ST_INIT;
                else if (i_Deal && r_Remaining != '0) w_Next = ST_DEAL;
      ST_DEAL:  w_Next = ST_READY;
      default:  w_Next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_We     = 1'b0;
    w_WrData = r_Rank;
    w_Addr   = r_Ptr;
    w_Busy   = (r_State >= ST_INIT) && (r_State <= ST_NEXT);
    w_Ready  = (r_State == ST_READY || r_State == ST_DEAL) && r_Remaining != '0;
    w_Empty  = (r_State == ST_READY) && r_Remaining == '0;
    case (r_State)
      ST_INIT: begin w_We = 1'b1; w_Addr = r_K; end
      ST_RD_I: w_Addr = r_I;
      ST_RD_J: w_Addr = r_J;
      ST_WR_I: begin w_We = 1'b1; w_Addr = r_I; w_WrData = r_RdData; end
      ST_WR_J: begin w_We = 1'b1; w_Addr = r_J; w_WrData = r_Ti; end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (w_We) r_Mem[w_Addr] <= w_WrData;
    r_RdData <= r_Mem[w_Addr];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_K         <= '0;
      r_Rank      <= CARD_W'(RANK_ACE);
      r_I         <= '0;
      r_J         <= '0;
      r_Ti        <= '0;
      r_Ptr       <= '0;
      r_Remaining <= '0;
      r_Card      <= '0;
      r_CardValid <= 1'b0;
    end else begin
      r_CardValid <= 1'b0;
      case (r_State)
        ST_IDLE, ST_READY: if (w_Next == ST_INIT) begin
          r_K         <= '0;
          r_Rank      <= CARD_W'(RANK_ACE);
          r_Remaining <= '0;
        end
        ST_INIT: begin
          r_K    <= r_K + 1'b1;
          r_Rank <= (r_Rank == CARD_W'(RANK_KING)) ? CARD_W'(RANK_ACE) : r_Rank + 1'b1;
          r_I    <= LAST;
        end
        ST_PICK: r_J  <= w_Cand;
        ST_RD_J: r_Ti <= r_RdData;
        ST_NEXT: if (r_I == ADDR_W'(1)) begin
          r_Ptr       <= '0;
          r_Remaining <= CNT_W'(DECK_SIZE);
        end else begin
          r_I <= r_I - 1'b1;
        end
        // Read of RAM[ptr] was issued while in READY
        ST_DEAL: begin
          r_Card      <= r_RdData;
          r_CardValid <= 1'b1;
          r_Ptr       <= r_Ptr + 1'b1;
          r_Remaining <= r_Remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_Card      = r_Card;
  assign o_CardValid = r_CardValid;
  assign o_Busy      = w_Busy;
  assign o_Ready     = w_Ready;
  assign o_Empty     = w_Empty;
  assign o_LowDeck   = w_Ready && (r_Remaining < CNT_W'(LOW_MARK));
  assign o_Remaining = r_Remaining;
  assign o_State     = r_State;
endmodule

// File: tb/tb_card_deck_shuffler.sv
// Bench: a deck-level model (Fisher-Yates over an array, driven by the LFSR sequence)
// is checked against the single-deck DUT every cycle; a two-deck instance is checked by hand values.
module tb_card_deck_shuffler;
  localparam int DS = 52;
  localparam int LOWM = 15;

  logic       clk = 1'b0;
  logic       rst, shf, dl, shf2, dl2;
  logic [3:0] card, card2, st, st2;
  logic       cv, busy, rdy, emp, low, cv2, busy2, rdy2, emp2, low2;
  logic [5:0] rem;
  logic [6:0] rem2;

  always #5 clk = ~clk;

  card_deck_shuffler #(.N_DECKS(1)) u0 (
    .i_Clk(clk), .i_Reset(rst), .i_Shuffle(shf), .i_Deal(dl), .o_Card(card), .o_CardValid(cv),
    .o_Busy(busy), .o_Ready(rdy), .o_Empty(emp), .o_LowDeck(low), .o_Remaining(rem), .o_State(st));

  card_deck_shuffler #(.N_DECKS(2), .LOW_MARK(15)) u1 (
    .i_Clk(clk), .i_Reset(rst), .i_Shuffle(shf2), .i_Deal(dl2), .o_Card(card2), .o_CardValid(cv2),
    .o_Busy(busy2), .o_Ready(rdy2), .o_Empty(emp2), .o_LowDeck(low2), .o_Remaining(rem2), .o_State(st2));

  int n_cmp = 0, n_bad = 0;
  int q[$], q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- deck-level reference model ----------------
  typedef enum {M_IDLE, M_BUSY, M_READY, M_DEAL} mmode_t;
  mmode_t      m_mode;
  int          m_left, m_rem, m_ptr;
  int          m_deck[DS];
  logic [15:0] m_lfsr;
  logic [3:0]  m_card;
  logic        m_cv;
  bit          m_live = 0;

  function automatic logic [15:0] lstep(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Builds the shuffled deck and the number of busy cycles the shuffle takes:
  // fill costs one cycle per card, each draw one cycle, each accepted swap five more.
  task automatic start_shuffle();
    logic [15:0] x;
    int cyc, j, t;
    x   = lstep(m_lfsr);
    cyc = DS;
    for (int k = 0; k < DS; k++) m_deck[k] = k % 13 + 1;
    repeat (DS) x = lstep(x);
    for (int i = DS - 1; i >= 1; i--) begin
      do begin
        j = int'(x[5:0]);
        x = lstep(x);
        cyc++;
      end while (j > i);
      t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
      repeat (5) x = lstep(x);
      cyc += 5;
    end
    m_mode = M_BUSY;
    m_left = cyc;
    m_rem  = 0;
  endtask

  always @(posedge clk) begin
    m_cv = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_rem = 0; m_ptr = 0; m_card = 4'd0; m_lfsr = 16'hACE1; m_live = 1;
    end else begin
      case (m_mode)
        M_IDLE:  if (shf) start_shuffle();
        M_BUSY:  begin
          m_left--;
          if (m_left == 0) begin m_mode = M_READY; m_rem = DS; m_ptr = 0; end
        end
        M_READY: if (shf) start_shuffle();
                 else if (dl && m_rem > 0) m_mode = M_DEAL;
        M_DEAL:  begin
          m_card = 4'(m_deck[m_ptr]); m_cv = 1'b1; m_ptr++; m_rem--; m_mode = M_READY;
        end
      endcase
      m_lfsr = lstep(m_lfsr);
    end
  end

  always @(negedge clk) if (m_live) begin
    chk("busy", busy, m_mode == M_BUSY);
    chk("ready", rdy, (m_mode == M_READY || m_mode == M_DEAL) && m_rem > 0);
    chk("empty", emp, m_mode == M_READY && m_rem == 0);
    chk("lowdeck", low, (m_mode == M_READY || m_mode == M_DEAL) && m_rem > 0 && m_rem < LOWM);
    chk("remaining", rem, m_rem);
    chk("cardvalid", cv, m_cv);
    chk("card", card, m_card);
    if (m_mode == M_BUSY) chk("state_busy", st >= 4'd1 && st <= 4'd7, 1);
    else chk("state", st, m_mode == M_IDLE ? 0 : (m_mode == M_READY ? 8 : 9));
  end

  always @(negedge clk) begin
    if (cv)  q.push_back(int'(card));
    if (cv2) q2.push_back(int'(card2));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit noise);
    int n = 0;
    while (busy && n < 5000) begin
      if (noise) begin dl = 1'($urandom_range(0, 1)); shf = ($urandom_range(0, 3) == 0); end
      tick();
      dl = 1'b0; shf = 1'b0;
      n++;
    end
    chk("done_timeout", busy, 0);
  endtask

  task automatic deal(input bit noise);
    tick($urandom_range(0, 2));
    dl = 1'b1; tick(); dl = 1'b0;
    if (noise) begin dl = 1'($urandom_range(0, 1)); shf = ($urandom_range(0, 3) == 0); end
    tick();
    dl = 1'b0; shf = 1'b0;
  endtask

  task automatic hist(input int qq[$], input int per, input string nm);
    int c[14];
    c = '{default: 0};
    foreach (qq[k]) if (qq[k] >= 1 && qq[k] <= 13) c[qq[k]]++;
    for (int r = 1; r <= 13; r++) chk(nm, c[r], per);
  endtask

  task automatic run_seq(input int off, output int s[DS]);
    rst = 1'b1; tick(); rst = 1'b0;
    tick(off);
    shf = 1'b1; tick(); shf = 1'b0;
    wait_done(0);
    q.delete();
    repeat (DS) deal(0);
    tick();
    for (int k = 0; k < DS; k++) s[k] = (k < q.size()) ? q[k] : -1;
  endtask

  initial begin
    int n;
    int s1[DS], s2[DS], s3[DS];
    bit same, diff;
    rst = 1'b1; shf = 1'b0; dl = 1'b0; shf2 = 1'b0; dl2 = 1'b0;
    tick(3);
    rst = 1'b0;

    // reset state, deal ignored in IDLE
    chk("rst_state", st, 0);
    chk("rst_remaining", rem, 0);
    dl = 1'b1; tick(); dl = 1'b0;
    chk("idle_deal_ignored", st, 0);

    // first shuffle: busy next cycle, fill phase is one cycle per card
    shf = 1'b1; tick(); shf = 1'b0;
    chk("t1_busy", busy, 1);
    n = 0;
    while (st == 4'd1 && n < 100) begin n++; tick(); end
    chk("t1_init_len", n, 52);
    wait_done(1);
    chk("t1_remaining", rem, 52);
    chk("t1_empty", emp, 0);
    chk("t1_ready", rdy, 1);

    // deal the whole shoe; first deal pins the two-edge latency
    q.delete();
    dl = 1'b1; tick(); dl = 1'b0;
    chk("lat_edge1", cv, 0);
    tick();
    chk("lat_edge2", cv, 1);
    repeat (DS - 1) deal(1);
    tick();
    chk("t2_count", q.size(), 52);
    hist(q, 4, "t2_hist");
    chk("t2_empty", emp, 1);
    dl = 1'b1; tick(); dl = 1'b0; tick(2);
    chk("t2_53rd_no_card", q.size(), 52);
    chk("t2_still_empty", emp, 1);

    // random partial deals interrupted by reshuffles
    repeat (3) begin
      n = $urandom_range(5, 40);
      repeat (n) deal(1);
      shf = 1'b1; dl = 1'($urandom_range(0, 1)); tick(); shf = 1'b0; dl = 1'b0;
      chk("reshuffle_busy", busy, 1);
      wait_done(1);
    end

    // shuffle and deal in the same cycle: shuffle wins
    q.delete();
    shf = 1'b1; dl = 1'b1; tick(); shf = 1'b0; dl = 1'b0;
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_no_valid", cv, 0);
    wait_done(1);
    chk("t4_no_card", q.size(), 0);
    chk("t4_remaining", rem, 52);

    // reset in the middle of a shuffle, then a clean shuffle
    shf = 1'b1; tick(); shf = 1'b0;
    tick(200);
    chk("t5_midshuffle", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_state", st, 0);
    chk("t5_outputs", {card, cv, busy, rdy, emp, low, rem}, 0);
    shf = 1'b1; tick(); shf = 1'b0;
    wait_done(1);
    q.delete();
    repeat (DS) deal(1);
    tick();
    hist(q, 4, "t5_hist");

    // determinism vs. shuffle start offset
    run_seq(5, s1);
    run_seq(5, s2);
    run_seq(6, s3);
    same = 1; diff = 0;
    for (int k = 0; k < DS; k++) begin
      if (s1[k] != s2[k]) same = 0;
      if (s1[k] != s3[k]) diff = 1;
    end
    chk("t6_same_offset_same_seq", same, 1);
    chk("t6_offset_changes_seq", diff, 1);

    // two-deck shoe
    shf2 = 1'b1; tick(); shf2 = 1'b0;
    n = 0;
    while (busy2 && n < 10000) begin tick(); n++; end
    chk("t3_done_timeout", busy2, 0);
    chk("t3_remaining_full", rem2, 104);
    q2.delete();
    for (int d = 0; d < 104; d++) begin
      dl2 = 1'b1; tick(); dl2 = 1'b0; tick();
      if (d == 89) begin
        chk("t3_remaining_90", rem2, 14);
        chk("t3_lowdeck_90", low2, 1);
      end
      if (d == 88) chk("t3_lowdeck_89", low2, 0);
    end
    tick();
    chk("t3_count", q2.size(), 104);
    hist(q2, 8, "t3_hist");
    chk("t3_empty", emp2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
